// File: rtl/spart_bus_arbiter.sv
// Two-requester round-robin arbiter and single-transaction sequencer that is the
// sole driver of the SPART processor-side bus (iocs/iorw/ioaddr/databus).
module spart_bus_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_we,
  input  logic [3:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  input  logic        rda,
  input  logic        tbr,
  output logic        iocs,
  output logic        iorw,
  output logic [1:0]  ioaddr,
  inout  logic [7:0]  databus
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  logic            g_q, last_gnt_q, we_q, err_q, expired_q;
  logic [1:0]      addr_q;
  logic [7:0]      wdata_q, rdata_q;
  logic [CW-1:0]   cnt_q;

  logic            gnt, accept, buf_rdy;

  always_comb begin
    state_d   = state_q;
    gnt       = last_gnt_q;
    accept    = 1'b0;
    req_ready = '0;
    buf_rdy   = (addr_q != 2'b00) || (we_q ? tbr : rda);

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          gnt       = (&req_valid) ? ~last_gnt_q : req_valid[1];
          accept    = 1'b1;
          req_ready = gnt ? 2'b10 : 2'b01;
          state_d   = WAIT;
        end
      end
      // Once the counter has reached TIMEOUT-1 the next WAIT cycle abandons
      // the transaction, giving the TIMEOUT+2 accept-to-response latency.
      WAIT: begin
        if (expired_q)    state_d = RESP;
        else if (buf_rdy) state_d = ACCESS;
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    iocs      = (state_q == ACCESS);
    iorw      = !((state_q == ACCESS) && we_q);
    ioaddr    = (state_q == ACCESS) ? addr_q : '0;
    rsp_valid = (state_q == RESP) ? (g_q ? 2'b10 : 2'b01) : '0;
    rsp_err   = (state_q == RESP) && err_q;
    rsp_data  = ((state_q == RESP) && !err_q && !we_q) ? rdata_q : '0;
  end

  assign databus = ((state_q == ACCESS) && we_q) ? wdata_q : 'z;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      g_q        <= 1'b0;
      last_gnt_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      expired_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            g_q        <= gnt;
            last_gnt_q <= gnt;
            we_q       <= req_we[gnt];
            addr_q     <= req_addr[{gnt, 1'b0} +: 2];
            wdata_q    <= req_wdata[{gnt, 3'b000} +: 8];
            rdata_q    <= '0;
            err_q      <= 1'b0;
            expired_q  <= 1'b0;
            cnt_q      <= '0;
          end
        end
        WAIT: begin
          if (expired_q) begin
            err_q <= 1'b1;
          end else if (!buf_rdy) begin
            if (cnt_q == CW'(TIMEOUT - 1)) expired_q <= 1'b1;
            else                           cnt_q     <= cnt_q + 1'b1;
          end
        end
        ACCESS: begin
          if (!we_q) rdata_q <= databus;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Self-checking bench for spart_bus_arbiter: directed scenarios plus random
// traffic, all scored against a transaction-timing reference model.
module tb_spart_bus_arbiter;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [3:0]  req_addr;
  logic [15:0] req_wdata;
  logic [7:0]  rsp_data;
  logic        rsp_err, rda, tbr, iocs, iorw;
  logic [1:0]  ioaddr;
  wire  [7:0]  databus;
  logic [7:0]  spart_rd;

  // SPART model drives the bus only while being read
  assign databus = (iocs && iorw) ? spart_rd : 8'hzz;

  always #5 clk = ~clk;

  spart_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rda(rda), .tbr(tbr), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit bus_released();
    return (databus === 8'hzz) || (databus === 8'h00);
  endfunction

  // next-cycle stimulus
  logic [1:0]  n_valid = '0, n_we = '0;
  logic [3:0]  n_addr = '0;
  logic [15:0] n_wd = '0;
  logic        n_rda = 1'b0, n_tbr = 1'b0;

  // reference model: one transaction in flight, described by its key cycles
  int   cyc = 0;
  bit   m_busy = 0, m_g = 0, m_we = 0, m_err = 0, m_last = 1;
  bit [1:0] m_addr;
  bit [7:0] m_wd, m_rd;
  int   m_acc_t, m_acc_n, m_rsp_n;
  int   obs_cyc[$];
  bit   obs_g[$];

  task automatic model_check();
    logic [1:0] e_rdy, e_rsp;
    bit e_cs, bufok;
    e_rdy = '0;
    e_rsp = '0;
    if (!m_busy) begin
      if (req_valid != 2'b00) begin
        m_g     = (req_valid == 2'b11) ? !m_last : req_valid[1];
        m_last  = m_g;
        m_we    = req_we[m_g];
        m_addr  = req_addr[2*m_g +: 2];
        m_wd    = req_wdata[8*m_g +: 8];
        m_busy  = 1;
        m_acc_t = cyc;
        m_acc_n = -1;
        m_rsp_n = -1;
        e_rdy   = m_g ? 2'b10 : 2'b01;
      end
    end else if (m_acc_n < 0 && m_rsp_n < 0) begin
      bufok = (m_addr != 2'b00) || (m_we ? tbr : rda);
      if (cyc <= m_acc_t + int'(TO) && bufok) begin
        m_acc_n = cyc + 1; m_rsp_n = cyc + 2; m_err = 0;
      end else if (cyc == m_acc_t + int'(TO) + 1) begin
        m_rsp_n = cyc + 1; m_err = 1;
      end
    end
    e_cs = m_busy && (cyc == m_acc_n);
    if (m_busy && cyc == m_rsp_n) e_rsp = m_g ? 2'b10 : 2'b01;

    check_eq("req_ready", 32'(req_ready), 32'(e_rdy));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
    check_eq("iocs", 32'(iocs), 32'(e_cs));
    if (e_cs) begin
      check_eq("iorw", 32'(iorw), 32'(!m_we));
      check_eq("ioaddr", 32'(ioaddr), 32'(m_addr));
      if (m_we) check_eq("wr_bus", 32'(databus), 32'(m_wd));
      else      m_rd = spart_rd;
    end else begin
      check_eq("bus_free", 32'(bus_released()), 32'd1);
    end
    if (e_rsp != 2'b00) begin
      check_eq("rsp_err", 32'(rsp_err), 32'(m_err));
      check_eq("rsp_data", 32'(rsp_data), (m_err || m_we) ? 32'd0 : 32'(m_rd));
      m_busy = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    req_valid = n_valid; req_we = n_we; req_addr = n_addr; req_wdata = n_wd;
    rda = n_rda; tbr = n_tbr;
    spart_rd = 8'($urandom);
    @(negedge clk);
    model_check();
    if (req_ready != 2'b00) begin
      obs_cyc.push_back(cyc);
      obs_g.push_back(req_ready[1]);
    end
    cyc++;
  endtask

  task automatic rand_drive(input int unsigned p);
    for (int i = 0; i < 2; i++) begin
      if (n_valid[i] && !req_ready[i]) begin
        if ($urandom_range(15) == 0) n_valid[i] = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        n_valid[i] = 1'b1;
        n_we[i] = 1'($urandom);
        n_addr[2*i +: 2] = 2'($urandom);
        n_wd[8*i +: 8] = 8'($urandom);
      end else begin
        n_valid[i] = 1'b0;
      end
    end
    n_rda = ($urandom_range(99) < p);
    n_tbr = ($urandom_range(99) < p);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int k_rsp;
    int n0;
    logic [7:0] byte_rd;

    rst = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    rda = 1'b0; tbr = 1'b0; spart_rd = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp", 32'(rsp_valid), 32'd0);
    check_eq("rst_iocs", 32'(iocs), 32'd0);
    check_eq("rst_iorw", 32'(iorw), 32'd1);
    check_eq("rst_ioaddr", 32'(ioaddr), 32'd0);
    check_eq("rst_data", 32'(rsp_data), 32'd0);
    check_eq("rst_err", 32'(rsp_err), 32'd0);
    check_eq("rst_bus", 32'(bus_released()), 32'd1);
    @(posedge clk); #1 rst = 1'b1;

    // single write
    n_valid = 2'b01; n_we = 2'b01; n_addr = 4'b0010; n_wd = 16'h008A; n_tbr = 1'b1; n_rda = 1'b1;
    step();
    check_eq("sw_accept", 32'(req_ready), 32'd1);
    n_valid = '0;
    step();
    step();
    check_eq("sw_iocs", 32'(iocs), 32'd1);
    check_eq("sw_bus", 32'(databus), 32'h8A);
    step();
    check_eq("sw_rsp", 32'(rsp_valid), 32'd1);
    step();

    // asynchronous reset in the middle of a write ACCESS
    n_valid = 2'b01; n_we = 2'b01; n_addr = 4'b0000; n_wd = 16'h003C;
    step();
    n_valid = '0;
    step();
    step();
    check_eq("rm_iocs_pre", 32'(iocs), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("rm_iocs", 32'(iocs), 32'd0);
    check_eq("rm_iorw", 32'(iorw), 32'd1);
    check_eq("rm_bus", 32'(bus_released()), 32'd1);
    req_valid = '0;
    m_busy = 0; m_last = 1;
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    repeat (4) step();

    // round-robin with both requesters always requesting status reads
    obs_cyc.delete(); obs_g.delete();
    n_valid = 2'b11; n_we = 2'b00; n_addr = 4'b0101;
    step();
    check_eq("rr_first", 32'(req_ready), 32'd1);
    repeat (15) step();
    n_valid = '0;
    repeat (4) step();
    check_eq("rr_count", 32'(obs_cyc.size()), 32'd4);
    for (int k = 1; k < 4 && k < obs_cyc.size(); k++) begin
      check_eq("rr_gap", 32'(obs_cyc[k] - obs_cyc[k-1]), 32'd4);
      check_eq("rr_alt", 32'(obs_g[k]), 32'(k % 2));
    end

    // read of the RX buffer gated on rda
    n_valid = 2'b10; n_we = 2'b00; n_addr = 4'b0000; n_rda = 1'b0;
    step();
    check_eq("rg_accept", 32'(req_ready), 32'd2);
    n_valid = '0;
    repeat (5) step();
    n_rda = 1'b1;
    step();
    step();
    check_eq("rg_iocs", 32'(iocs), 32'd1);
    byte_rd = spart_rd;
    step();
    check_eq("rg_rsp", 32'(rsp_valid), 32'd2);
    check_eq("rg_data", 32'(rsp_data), 32'(byte_rd));
    step();

    // TX write timing out on tbr
    n_valid = 2'b10; n_we = 2'b10; n_addr = 4'b0000; n_wd = 16'h7700; n_tbr = 1'b0;
    step();
    check_eq("to_accept", 32'(req_ready), 32'd2);
    n_valid = '0;
    k_rsp = -1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (rsp_valid[1] && k_rsp < 0) begin
        k_rsp = k;
        check_eq("to_err", 32'(rsp_err), 32'd1);
      end
    end
    check_eq("to_latency", 32'(k_rsp), 32'(TO + 2));

    // requester 0 withdraws while requester 1 occupies the bus
    obs_cyc.delete(); obs_g.delete();
    n_valid = 2'b10; n_we = 2'b10; n_addr = 4'b0000; n_wd = 16'h5500; n_tbr = 1'b0;
    step();
    n_valid = 2'b01; n_we = 2'b10; n_addr = 4'b0001; n_wd = 16'h5511;
    step();
    n_valid = 2'b00;
    n0 = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) n_tbr = 1'b1;
      step();
      if (req_ready[0] || rsp_valid[0]) n0++;
    end
    check_eq("wd_req0", 32'(n0), 32'd0);
    check_eq("wd_grants", 32'(obs_cyc.size()), 32'd1);

    // random traffic with varying buffer readiness
    for (int ph = 0; ph < 3; ph++) begin
      for (int k = 0; k < 1000; k++) begin
        rand_drive(ph == 0 ? 70 : (ph == 1 ? 30 : 5));
        step();
      end
    end
    n_valid = '0; n_rda = 1'b1; n_tbr = 1'b1;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
